rv_cpu_core: RTL and testbench

//  5-stage in-order RV32I pipeline (IF/ID/EX/MEM/WB) forming the processor core of the SoC.

---
 rtl/rv_cpu_core_pkg.sv | 98 +++++++++
 rtl/rv_cpu_core_register_file.sv | 24 ++
 rtl/rv_cpu_core.sv | 104 ++++++++++
 tb/tb_rv_cpu_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_cpu_core_pkg.sv
// rv_cpu_core_pkg: shared types, opcodes and decode/ALU helpers for the RV32I core
package rv_cpu_core_pkg;
  typedef enum logic [2:0] {MEM_B = 3'd0, MEM_H = 3'd1, MEM_W = 3'd2, MEM_BU = 3'd4, MEM_HU = 3'd5} mem_op_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_B
  } alu_op_t;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jal;
    logic jalr;
    logic a_pc;
    logic b_imm;
    alu_op_t alu_op;
    mem_op_t mem_op;
  } ctrl_t;

  function automatic alu_op_t alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Unsupported opcodes fall through with all enables low, i.e. they retire as NOPs.
  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    c.mem_op = mem_op_t'(ins[14:12]);
    case (ins[6:0])
      OP_LUI:    begin c.reg_wr = 1'b1; c.b_imm = 1'b1; c.alu_op = ALU_B; end
      OP_AUIPC:  begin c.reg_wr = 1'b1; c.a_pc = 1'b1; c.b_imm = 1'b1; end
      OP_JAL:    begin c.reg_wr = 1'b1; c.jal = 1'b1; end
      OP_JALR:   begin c.reg_wr = 1'b1; c.jalr = 1'b1; end
      OP_BRANCH: c.branch = 1'b1;
      OP_LOAD:   begin c.reg_wr = 1'b1; c.mem_rd = 1'b1; c.b_imm = 1'b1; end
      OP_STORE:  begin c.mem_wr = 1'b1; c.b_imm = 1'b1; end
      OP_IMM:    begin c.reg_wr = 1'b1; c.b_imm = 1'b1; c.alu_op = alu_of(ins[14:12], ins[14:12] == F3_SR && ins[30]); end
      OP_REG:    begin c.reg_wr = 1'b1; c.alu_op = alu_of(ins[14:12], ins[31:25] == F7_ALT); end
      default:   ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OP_LUI || op == OP_AUIPC) ? {ins[31:12], 12'b0} :
           op == OP_JAL    ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
           op == OP_BRANCH ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
           op == OP_STORE  ? {{21{ins[31]}}, ins[30:25], ins[11:7]} :
                             {{21{ins[31]}}, ins[30:20]};
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_B:    return b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rv_cpu_core_register_file.sv
// register_file: 32x32 register file, two async read ports with write-through, one sync write port
module register_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] registers [32];

  always_ff @(posedge clk_i) begin
    if (rst_i)
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    else if (we_i && wa_i != 5'd0)
      registers[wa_i] <= wd_i;
  end

  assign rd1_o = ra1_i == 5'd0 ? '0 : (we_i && wa_i == ra1_i) ? wd_i : registers[ra1_i];
  assign rd2_o = ra2_i == 5'd0 ? '0 : (we_i && wa_i == ra2_i) ? wd_i : registers[ra2_i];
endmodule

// File: rtl/rv_cpu_core.sv
// rv_cpu_core: 5-stage in-order RV32I pipeline with forwarding, load-use stall and EX-stage redirect
module rv_cpu_core
  import rv_cpu_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_if,
  output logic        mem_wr_en,
  output mem_op_t     mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_ins_q, ifid_pc_q;
  ctrl_t       idex_ctrl_q;
  logic [31:0] idex_pc_q, idex_a_q, idex_b_q, idex_imm_q;
  logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
  logic [2:0]  idex_f3_q;
  logic        exmem_wr_q, exmem_ld_q, exmem_st_q;
  mem_op_t     exmem_op_q;
  logic [31:0] exmem_res_q, exmem_sd_q;
  logic [4:0]  exmem_rd_q;
  logic        memwb_wr_q;
  logic [31:0] memwb_data_q;
  logic [4:0]  memwb_rd_q;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] id_a, id_b, fa, fb, ex_res, ex_tgt;
  logic        ex_taken, ld_use;

  assign id_rs1 = ifid_ins_q[19:15];
  assign id_rs2 = ifid_ins_q[24:20];

  register_file register_file_h (
    .clk_i(clk), .rst_i(resetn), .we_i(memwb_wr_q), .wa_i(memwb_rd_q), .wd_i(memwb_data_q),
    .ra1_i(id_rs1), .ra2_i(id_rs2), .rd1_o(id_a), .rd2_o(id_b)
  );

  always_comb begin
    fa = (exmem_wr_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q) ? exmem_res_q :
         (memwb_wr_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs1_q) ? memwb_data_q : idex_a_q;
    fb = (exmem_wr_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q) ? exmem_res_q :
         (memwb_wr_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs2_q) ? memwb_data_q : idex_b_q;
    ex_res = (idex_ctrl_q.jal || idex_ctrl_q.jalr) ? idex_pc_q + 32'd4 :
             alu(idex_ctrl_q.alu_op, idex_ctrl_q.a_pc ? idex_pc_q : fa, idex_ctrl_q.b_imm ? idex_imm_q : fb);
    ex_taken = idex_ctrl_q.jal || idex_ctrl_q.jalr || (idex_ctrl_q.branch && br_taken(idex_f3_q, fa, fb));
    ex_tgt = idex_ctrl_q.jalr ? (fa + idex_imm_q) & ~32'd1 : idex_pc_q + idex_imm_q;
    ld_use = idex_ctrl_q.mem_rd && (idex_rd_q == id_rs1 || idex_rd_q == id_rs2);
    pc_d = ex_taken ? ex_tgt : ld_use ? pc_q : pc_q + 32'd4;
  end

  assign pc_out      = pc_q;
  assign mem_wr_en   = exmem_st_q && !resetn;
  assign mem_op      = exmem_op_q;
  assign mem_addr    = exmem_res_q;
  assign mem_data_in = exmem_sd_q;

  // A redirect flushes IF/ID and ID/EX and overrides any simultaneous load-use hold.
  always_ff @(posedge clk) begin
    if (resetn) begin
      pc_q        <= RESET_PC;
      ifid_ins_q  <= NOP;
      ifid_pc_q   <= RESET_PC;
      idex_ctrl_q <= '0;
      exmem_wr_q  <= 1'b0;
      exmem_ld_q  <= 1'b0;
      exmem_st_q  <= 1'b0;
      memwb_wr_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (ex_taken) begin
        ifid_ins_q  <= NOP;
        idex_ctrl_q <= '0;
      end else if (ld_use) begin
        idex_ctrl_q <= '0;
      end else begin
        ifid_ins_q  <= instr_if;
        ifid_pc_q   <= pc_q;
        idex_ctrl_q <= decode(ifid_ins_q);
      end
      idex_pc_q    <= ifid_pc_q;
      idex_a_q     <= id_a;
      idex_b_q     <= id_b;
      idex_imm_q   <= imm_of(ifid_ins_q);
      idex_rs1_q   <= id_rs1;
      idex_rs2_q   <= id_rs2;
      idex_rd_q    <= ifid_ins_q[11:7];
      idex_f3_q    <= ifid_ins_q[14:12];
      exmem_wr_q   <= idex_ctrl_q.reg_wr;
      exmem_ld_q   <= idex_ctrl_q.mem_rd;
      exmem_st_q   <= idex_ctrl_q.mem_wr;
      exmem_op_q   <= idex_ctrl_q.mem_op;
      exmem_res_q  <= ex_res;
      exmem_sd_q   <= fb;
      exmem_rd_q   <= idex_rd_q;
      memwb_wr_q   <= exmem_wr_q;
      memwb_rd_q   <= exmem_rd_q;
      memwb_data_q <= exmem_ld_q ? mem_data_out : exmem_res_q;
    end
  end
endmodule

// File: tb/tb_rv_cpu_core.sv
// tb_rv_cpu_core: directed programs for rv_cpu_core with behavioural instruction and data memories
module tb_rv_cpu_core;
  import rv_cpu_core_pkg::*;
  logic        clk = 1'b0, resetn = 1'b0, dm_clr = 1'b0;
  logic [31:0] pc_out, instr_if, mem_addr, mem_data_in, mem_data_out;
  logic        mem_wr_en;
  mem_op_t     mem_op;
  logic [31:0] imem [64];
  logic [7:0]  dmem [256];
  logic [7:0]  da, b0, b1, b2, b3;
  int          tests = 0, fails = 0;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  rv_cpu_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .resetn(resetn), .pc_out(pc_out), .instr_if(instr_if), .mem_wr_en(mem_wr_en),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign instr_if = imem[pc_out[7:2]];
  assign da = mem_addr[7:0];
  assign b0 = dmem[da];
  assign b1 = dmem[da + 8'd1];
  assign b2 = dmem[da + 8'd2];
  assign b3 = dmem[da + 8'd3];

  always_comb begin
    case (mem_op)
      MEM_B:   mem_data_out = {{24{b0[7]}}, b0};
      MEM_BU:  mem_data_out = {24'b0, b0};
      MEM_H:   mem_data_out = {{16{b1[7]}}, b1, b0};
      MEM_HU:  mem_data_out = {16'b0, b1, b0};
      default: mem_data_out = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (dm_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (mem_wr_en) begin
      dmem[da] <= mem_data_in[7:0];
      if (mem_op != MEM_B) dmem[da + 8'd1] <= mem_data_in[15:8];
      if (mem_op == MEM_W) begin
        dmem[da + 8'd2] <= mem_data_in[23:16];
        dmem[da + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  function automatic logic [31:0] e_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return e_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] xr(input int i);
    return dut.register_file_h.registers[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = NOPW;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    dm_clr = 1'b1;
    tick(1);
    resetn = 1'b0;
    dm_clr = 1'b0;
  endtask

  task automatic load_use_prog();
    clear_imem();
    imem[0] = e_addi(5'd1, 5'd0, -32'sd128);
    imem[1] = e_sw(5'd1, 5'd0, 32'd0);
    imem[2] = e_i(32'd0, 5'd0, 3'd0, 5'd4, 7'h03);
    imem[3] = e_addi(5'd5, 5'd4, 32'd1);
    imem[4] = e_br(3'd0, 5'd0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset, forwarding and a few ALU ops
    clear_imem();
    imem[0] = e_addi(5'd1, 5'd0, 32'd5);
    imem[1] = e_addi(5'd2, 5'd1, 32'd3);
    imem[2] = e_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    imem[3] = e_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd6);
    imem[4] = e_r(7'h00, 5'd6, 5'd1, 3'd3, 5'd7);
    imem[5] = e_r(7'h00, 5'd1, 5'd6, 3'd2, 5'd8);
    imem[6] = e_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd9);
    do_reset();
    check("reset_pc", pc_out, 32'h0);
    check("reset_wr_en", {31'b0, mem_wr_en}, 32'h0);
    for (int i = 1; i < 32; i++) check($sformatf("reset_x%0d", i), xr(i), 32'h0);
    tick(1); check("pc_c1", pc_out, 32'h4);
    tick(1); check("pc_c2", pc_out, 32'h8);
    tick(1); check("pc_c3", pc_out, 32'hC);
    tick(15);
    check("dep_x1", xr(1), 32'd5);
    check("dep_x2", xr(2), 32'd8);
    check("dep_x3", xr(3), 32'd13);
    check("sub_x6", xr(6), 32'hFFFF_FFFD);
    check("sltu_x7", xr(7), 32'd1);
    check("slt_x8", xr(8), 32'd1);
    check("sll_x9", xr(9), 32'h500);

    // Branches taken and not taken, each followed by wrong-path writes
    clear_imem();
    imem[0]  = e_addi(5'd10, 5'd0, 32'd1);
    imem[1]  = e_br(3'd0, 5'd10, 5'd10, 32'd12);
    imem[2]  = e_addi(5'd20, 5'd0, 32'd99);
    imem[3]  = e_addi(5'd21, 5'd0, 32'd99);
    imem[4]  = e_br(3'd0, 5'd10, 5'd0, 32'd8);
    imem[5]  = e_addi(5'd11, 5'd0, 32'd2);
    imem[6]  = e_br(3'd1, 5'd11, 5'd10, 32'd12);
    imem[7]  = e_addi(5'd22, 5'd0, 32'd99);
    imem[8]  = e_addi(5'd23, 5'd0, 32'd99);
    imem[9]  = e_br(3'd1, 5'd10, 5'd10, 32'd8);
    imem[10] = e_addi(5'd12, 5'd0, 32'd3);
    imem[11] = e_br(3'd0, 5'd0, 5'd0, 32'd0);
    imem[12] = e_addi(5'd24, 5'd0, 32'd99);
    do_reset();
    tick(100);
    check("br_x10", xr(10), 32'd1);
    check("br_x11", xr(11), 32'd2);
    check("br_x12", xr(12), 32'd3);
    for (int i = 20; i < 25; i++) check($sformatf("wrongpath_x%0d", i), xr(i), 32'h0);
    check("br_halt_pc", {31'b0, pc_out == 32'h2C || pc_out == 32'h30 || pc_out == 32'h34}, 32'd1);

    // Store then load-use
    load_use_prog();
    do_reset();
    tick(4);
    check("st_wr_en", {31'b0, mem_wr_en}, 32'd1);
    check("st_addr", mem_addr, 32'h0);
    check("st_data", mem_data_in, 32'hFFFF_FF80);
    check("st_op", {29'b0, mem_op}, {29'b0, MEM_W});
    check("lu_pc_c4", pc_out, 32'h10);
    tick(1);
    check("lu_pc_stall", pc_out, 32'h10);
    check("ld_op", {29'b0, mem_op}, {29'b0, MEM_B});
    check("ld_wr_en", {31'b0, mem_wr_en}, 32'd0);
    tick(1);
    check("lu_pc_c6", pc_out, 32'h14);
    tick(10);
    check("lu_x4", xr(4), 32'hFFFF_FF80);
    check("lu_x5", xr(5), 32'hFFFF_FF81);
    check("lu_dmem", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'hFFFF_FF80);

    // JAL / JALR
    clear_imem();
    imem[0] = e_addi(5'd5, 5'd0, 32'd7);
    imem[4] = e_jal(5'd1, 32'd8);
    imem[5] = e_br(3'd0, 5'd0, 5'd0, 32'd0);
    imem[6] = e_i(32'd0, 5'd1, 3'd0, 5'd0, 7'h67);
    imem[7] = e_addi(5'd6, 5'd0, 32'd99);
    imem[8] = e_addi(5'd7, 5'd0, 32'd99);
    do_reset();
    tick(7);
    check("jal_target", pc_out, 32'h18);
    tick(3);
    check("jalr_target", pc_out, 32'h14);
    tick(10);
    check("jal_x1", xr(1), 32'h14);
    check("jal_x5", xr(5), 32'd7);
    check("jalr_wp_x6", xr(6), 32'h0);
    check("jalr_wp_x7", xr(7), 32'h0);

    // Reset arriving while a store sits in MEM
    load_use_prog();
    do_reset();
    tick(4);
    check("mid_st_pending", {31'b0, mem_wr_en}, 32'd1);
    resetn = 1'b1;
    #1;
    check("mid_wr_masked", {31'b0, mem_wr_en}, 32'd0);
    tick(1);
    resetn = 1'b0;
    check("mid_pc", pc_out, 32'h0);
    check("mid_dmem", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'h0);
    check("mid_x1", xr(1), 32'h0);
    tick(1);
    check("mid_pc_next", pc_out, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
